// File: rtl/gated_d_shift_reg_pkg.sv
// Shared definitions for the gated D shift register and its stage cell.
package gated_d_shift_reg_pkg;

   // Operating mode encodings applied on every gated rising edge.
   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage : gated_d_shift_reg_pkg

// File: rtl/gated_d_shift_reg_stage.sv
// One WIDTH-bit pipeline stage: async-reset flop, gate-qualified update and a
// next-value mux selecting shift-in, parallel load, clear or hold.
module gated_d_stage
   import gated_d_shift_reg_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             g,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [WIDTH-1:0] load_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_next;

   // Select the value this stage takes on the next gated edge.
   always_comb begin
      // NOTE: default first so every path assigns q_next; no latch is inferred.
      q_next = q;
      case (mode)
         MODE_SHIFT: q_next = shift_in;
         MODE_LOAD:  q_next = load_in;
         MODE_CLEAR: q_next = '0;
         default:    q_next = q;
      endcase
   end

   // Stage register: async clear, updates only while the gate is open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every stage is a plain flop, so all of them are reset; there is no
         // RAM here whose contents would be left unreset.
         q <= '0;
      end else if (g) begin
         // NOTE: non-blocking so all stages sample their neighbours' old values.
         q <= q_next;
      end
   end

endmodule : gated_d_stage

// File: rtl/gated_d_shift_reg.sv
// DEPTH-stage, WIDTH-bit gated register pipeline with shift/load/hold/clear,
// true/complement outputs from the last stage and a saturating fill count.
module gated_d_shift_reg
   import gated_d_shift_reg_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   g,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       d,
   input  logic [DEPTH*WIDTH-1:0] pd,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       qn,
   output logic [DEPTH*WIDTH-1:0] pq,
   output logic [CW-1:0]          count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] stage [DEPTH];
   logic [CW-1:0]    count_next;

   // Stage 0 shifts in d; every later stage shifts in its predecessor.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] shift_src;

      if (i == 0) begin : g_first
         assign shift_src = d;
      end else begin : g_rest
         assign shift_src = stage[i-1];
      end

      gated_d_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .g        (g),
         .mode     (mode),
         .shift_in (shift_src),
         .load_in  (pd[i*WIDTH +: WIDTH]),
         .q        (stage[i])
      );

      assign pq[i*WIDTH +: WIDTH] = stage[i];
   end

   assign q  = stage[DEPTH-1];
   assign qn = ~stage[DEPTH-1];

   // Fill count: shift adds one up to DEPTH, load fills, clear empties.
   always_comb begin
      count_next = count;
      case (mode)
         MODE_SHIFT: count_next = (count == DEPTH_C) ? DEPTH_C : count + 1'b1;
         MODE_LOAD:  count_next = DEPTH_C;
         MODE_CLEAR: count_next = '0;
         default:    count_next = count;
      endcase
   end

   // Fill count register, frozen with the stages while the gate is closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (g) begin
         count <= count_next;
      end
   end

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

endmodule : gated_d_shift_reg

// File: tb/tb_gated_d_shift_reg.sv
// Directed bench for gated_d_shift_reg: three configurations driven in lock
// step, expected state queued at drive time and compared after each edge.
module tb_gated_d_shift_reg;

   localparam logic [1:0] HOLD  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] LOAD  = 2'b10;
   localparam logic [1:0] CLEAR = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       g;
   logic [1:0] mode;

   // WIDTH=1, DEPTH=4
   logic [0:0] d_w1, q_w1, qn_w1;
   logic [3:0] pd_w1, pq_w1;
   logic [2:0] count_w1;
   logic       full_w1, empty_w1;
   // WIDTH=2, DEPTH=4
   logic [1:0] d_w2, q_w2, qn_w2;
   logic [7:0] pd_w2, pq_w2;
   logic [2:0] count_w2;
   logic       full_w2, empty_w2;
   // WIDTH=1, DEPTH=1
   logic [0:0] d_d1, q_d1, qn_d1, pd_d1, pq_d1;
   logic [0:0] count_d1;
   logic       full_d1, empty_d1;

   gated_d_shift_reg #(.WIDTH(1), .DEPTH(4)) u_w1 (
      .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d_w1), .pd(pd_w1),
      .q(q_w1), .qn(qn_w1), .pq(pq_w1), .count(count_w1), .full(full_w1), .empty(empty_w1));

   gated_d_shift_reg #(.WIDTH(2), .DEPTH(4)) u_w2 (
      .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d_w2), .pd(pd_w2),
      .q(q_w2), .qn(qn_w2), .pq(pq_w2), .count(count_w2), .full(full_w2), .empty(empty_w2));

   gated_d_shift_reg #(.WIDTH(1), .DEPTH(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d_d1), .pd(pd_d1),
      .q(q_d1), .qn(qn_d1), .pq(pq_d1), .count(count_d1), .full(full_d1), .empty(empty_d1));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] pq_w1;
      int         c_w1;
      logic [7:0] pq_w2;
      int         c_w2;
      logic       pq_d1;
      int         c_d1;
   } exp_t;

   exp_t sb[$];

   // Reference state, advanced from the behavioural description at drive time.
   logic [3:0] m_w1;
   logic [7:0] m_w2;
   logic       m_d1;
   int         mc_w1, mc_w2, mc_d1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      check({tag, " w1.pq"},    32'(pq_w1),    32'(e.pq_w1));
      check({tag, " w1.q"},     32'(q_w1),     32'(e.pq_w1[3]));
      check({tag, " w1.qn"},    32'(qn_w1),    32'(1'(~e.pq_w1[3])));
      check({tag, " w1.count"}, 32'(count_w1), 32'(e.c_w1));
      check({tag, " w1.full"},  32'(full_w1),  32'(e.c_w1 == 4));
      check({tag, " w1.empty"}, 32'(empty_w1), 32'(e.c_w1 == 0));
      check({tag, " w2.pq"},    32'(pq_w2),    32'(e.pq_w2));
      check({tag, " w2.q"},     32'(q_w2),     32'(e.pq_w2[7:6]));
      check({tag, " w2.qn"},    32'(qn_w2),    32'(2'(~e.pq_w2[7:6])));
      check({tag, " w2.count"}, 32'(count_w2), 32'(e.c_w2));
      check({tag, " w2.full"},  32'(full_w2),  32'(e.c_w2 == 4));
      check({tag, " w2.empty"}, 32'(empty_w2), 32'(e.c_w2 == 0));
      check({tag, " d1.q"},     32'(q_d1),     32'(e.pq_d1));
      check({tag, " d1.pq"},    32'(pq_d1),    32'(e.pq_d1));
      check({tag, " d1.qn"},    32'(qn_d1),    32'(1'(~e.pq_d1)));
      check({tag, " d1.count"}, 32'(count_d1), 32'(e.c_d1));
      check({tag, " d1.full"},  32'(full_d1),  32'(e.c_d1 == 1));
      check({tag, " d1.empty"}, 32'(empty_d1), 32'(e.c_d1 == 0));
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.pq_w1 = m_w1; e.c_w1 = mc_w1;
      e.pq_w2 = m_w2; e.c_w2 = mc_w2;
      e.pq_d1 = m_d1; e.c_d1 = mc_d1;
      return e;
   endfunction

   task automatic model_reset();
      m_w1 = '0; m_w2 = '0; m_d1 = 1'b0;
      mc_w1 = 0; mc_w2 = 0; mc_d1 = 0;
   endtask

   // Drive one cycle of stimulus, queue the expected state, compare after the edge.
   task automatic step(input string tag, input logic gi, input logic [1:0] mi,
                       input logic [0:0] dw1, input logic [1:0] dw2, input logic [0:0] dd,
                       input logic [3:0] pw1, input logic [7:0] pw2, input logic [0:0] pdd);
      exp_t e;
      g = gi; mode = mi;
      d_w1 = dw1; d_w2 = dw2; d_d1 = dd;
      pd_w1 = pw1; pd_w2 = pw2; pd_d1 = pdd;
      if (gi === 1'b1) begin
         case (mi)
            SHIFT: begin
               m_w1 = {m_w1[2:0], dw1};
               m_w2 = {m_w2[5:0], dw2};
               m_d1 = dd;
               mc_w1 = (mc_w1 < 4) ? mc_w1 + 1 : 4;
               mc_w2 = (mc_w2 < 4) ? mc_w2 + 1 : 4;
               mc_d1 = 1;
            end
            LOAD: begin
               m_w1 = pw1; m_w2 = pw2; m_d1 = pdd;
               mc_w1 = 4; mc_w2 = 4; mc_d1 = 1;
            end
            CLEAR: model_reset();
            default: ;
         endcase
      end
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare_all(tag, e);
   endtask

   initial begin
      // Reset held while the gate is open and SHIFT requested with d=1.
      rst_n = 1'b0; g = 1'b1; mode = SHIFT;
      d_w1 = 1'b1; d_w2 = 2'b11; d_d1 = 1'b1;
      pd_w1 = '1; pd_w2 = '1; pd_d1 = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset", snapshot());
      g = 1'b0; mode = HOLD;
      #2 rst_n = 1'b1;

      // Four shifts: d_w1 = 1,0,1,1.
      step("shift1", 1'b1, SHIFT, 1'b1, 2'd3, 1'b1, '0, '0, '0);
      step("shift2", 1'b1, SHIFT, 1'b0, 2'd0, 1'b0, '0, '0, '0);
      step("shift3", 1'b1, SHIFT, 1'b1, 2'd2, 1'b1, '0, '0, '0);
      step("shift4", 1'b1, SHIFT, 1'b1, 2'd1, 1'b1, '0, '0, '0);
      check("shift4 w1.pq literal", 32'(pq_w1), 32'h0000_000B);
      check("shift4 w1.full literal", 32'(full_w1), 32'd1);

      // Gate closed: modes toggle and data is unknown, nothing may change.
      step("gate0", 1'b0, SHIFT, 'x, 'x, 'x, 'x, 'x, 'x);
      step("gate1", 1'b0, LOAD,  'x, 'x, 'x, 'x, 'x, 'x);
      step("gate2", 1'b0, CLEAR, 'x, 'x, 'x, 'x, 'x, 'x);
      step("gate3", 1'b0, SHIFT, 'x, 'x, 'x, 'x, 'x, 'x);
      step("gate4", 1'b0, 'x,    'x, 'x, 'x, 'x, 'x, 'x);
      step("resume", 1'b1, SHIFT, 1'b0, 2'd2, 1'b0, '0, '0, '0);
      step("hold",   1'b1, HOLD,  1'b1, 2'd3, 1'b1, '1, '1, '1);

      // Parallel load then clear.
      step("load", 1'b1, LOAD, 1'b0, 2'd0, 1'b0, 4'b0110, 8'hA5, 1'b1);
      check("load w2.q literal", 32'(q_w2), 32'd2);
      check("load w2.pq literal", 32'(pq_w2), 32'hA5);
      step("clear", 1'b1, CLEAR, 1'b1, 2'd1, 1'b1, '1, '1, '1);

      // Saturation: six shifts, q ends on the third value shifted in.
      step("sat1", 1'b1, SHIFT, 1'b1, 2'd1, 1'b1, '0, '0, '0);
      step("sat2", 1'b1, SHIFT, 1'b1, 2'd2, 1'b0, '0, '0, '0);
      step("sat3", 1'b1, SHIFT, 1'b0, 2'd3, 1'b1, '0, '0, '0);
      step("sat4", 1'b1, SHIFT, 1'b1, 2'd0, 1'b0, '0, '0, '0);
      step("sat5", 1'b1, SHIFT, 1'b0, 2'd1, 1'b1, '0, '0, '0);
      step("sat6", 1'b1, SHIFT, 1'b0, 2'd2, 1'b0, '0, '0, '0);
      check("sat6 w1.q literal", 32'(q_w1), 32'd0);
      check("sat6 w2.q literal", 32'(q_w2), 32'd3);
      check("sat6 w1.count literal", 32'(count_w1), 32'd4);

      // Reset asserted between edges while shifting.
      g = 1'b1; mode = SHIFT; d_w1 = 1'b1; d_w2 = 2'd3; d_d1 = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("midreset", snapshot());
      @(negedge clk);
      rst_n = 1'b1;
      g = 1'b0;
      @(posedge clk);
      #1;

      // Single-stage config: SHIFT d=1 appears on q after one edge.
      step("d1shift", 1'b1, SHIFT, 1'b0, 2'd0, 1'b1, '0, '0, '0);
      check("d1shift d1.q literal", 32'(q_d1), 32'd1);

      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_gated_d_shift_reg
